// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bus of the FIFO write-port arbiter.
// The slave modport is the arbiter's view; master is the requesters + FIFO view.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DataWidth = 8
);
    localparam int unsigned GrantW = $clog2(NumReq);

    logic [NumReq-1:0]           i_req_valid;
    logic [NumReq*DataWidth-1:0] i_req_data;
    logic [NumReq-1:0]           i_req_last;
    logic [NumReq-1:0]           o_req_ready;
    logic [DataWidth-1:0]        o_fifo_wr_data;
    logic                        o_fifo_wr_en;
    logic                        i_fifo_full;
    logic [GrantW-1:0]           o_grant_id;
    logic                        o_busy;
    logic [15:0]                 o_stall_cnt;

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_fifo_full,
        output o_req_ready, o_fifo_wr_data, o_fifo_wr_en, o_grant_id, o_busy, o_stall_cnt
    );

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_fifo_full,
        input  o_req_ready, o_fifo_wr_data, o_fifo_wr_en, o_grant_id, o_busy, o_stall_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NumReq burst requesters.
// Optional stall statistic enabled by defining FIFO_WR_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DataWidth = 8,
    parameter int unsigned MaxBurst  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int unsigned GrantW = $clog2(NumReq);
    localparam int unsigned CntW   = $clog2(MaxBurst + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            r_state;
    logic [GrantW-1:0] r_rr_ptr;
    logic [GrantW-1:0] r_grant_id;
    logic [CntW-1:0]   r_beat_cnt;
    logic              r_busy;

    logic [GrantW-1:0] w_sel;
    logic              w_any;
    logic [GrantW-1:0] w_next_ptr;
    logic              w_in_grant;
    logic              w_gvalid;
    logic              w_glast;
    logic              w_acc;
    logic              w_release;

    // First valid requester at or above rr_ptr, wrapping modulo NumReq.
    always_comb begin : sel_search
        logic [GrantW-1:0] idx;
        w_any = 1'b0;
        w_sel = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = GrantW'((32'(r_rr_ptr) + i) % NumReq);
            if (!w_any && bus.i_req_valid[idx]) begin
                w_any = 1'b1;
                w_sel = idx;
            end
        end
    end

    assign w_in_grant = (r_state == GRANT);
    assign w_gvalid   = bus.i_req_valid[r_grant_id];
    assign w_glast    = bus.i_req_last[r_grant_id];
    assign w_acc      = w_in_grant & w_gvalid & ~bus.i_fifo_full;
    assign w_release  = w_acc & (w_glast | (r_beat_cnt == CntW'(MaxBurst - 1)));
    assign w_next_ptr = (r_grant_id == GrantW'(NumReq - 1)) ? '0 : r_grant_id + 1'b1;

    assign bus.o_req_ready    = (w_in_grant && !bus.i_fifo_full) ? (NumReq'(1) << r_grant_id) : '0;
    assign bus.o_fifo_wr_en   = w_acc;
    assign bus.o_fifo_wr_data = w_acc ? bus.i_req_data[r_grant_id*DataWidth +: DataWidth] : '0;
    assign bus.o_grant_id     = r_grant_id;
    assign bus.o_busy         = r_busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_sel;
                        r_busy     <= 1'b1;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_grant_id <= '0;
                        r_rr_ptr   <= w_next_ptr;
                        r_beat_cnt <= '0;
                    end else if (w_acc) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Counts granted cycles where the owner has a beat but the FIFO is full.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_in_grant && w_gvalid && bus.i_fifo_full && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.o_stall_cnt = r_stall_cnt;
`else
    assign bus.o_stall_cnt = '0;
`endif

endmodule
